// File: rtl/riscy_fetch_if.sv
// Sequencer and program-memory signals of the RISCY fetch stage in one bundle.
// slave is the fetch stage's view; master is the sequencer/memory side.
interface riscy_fetch_if #(
   parameter int AW  = 5,
   parameter int DW  = 8,
   parameter int OPW = 3
);
   logic           fetch_req;
   logic           ir_valid;
   logic           ir_ack;
   logic [OPW-1:0] opcode;
   logic [AW-1:0]  operand;
   logic [AW-1:0]  pc;
   logic           pc_load;
   logic [AW-1:0]  pc_target;
   logic           pc_skip;
   logic           mem_rd;
   logic [AW-1:0]  mem_addr;
   logic [DW-1:0]  mem_rdata;
   logic           mem_ack;
   logic           busy;

   modport slave (
      input  fetch_req, ir_ack, pc_load, pc_target, pc_skip, mem_rdata, mem_ack,
      output ir_valid, opcode, operand, pc, mem_rd, mem_addr, busy
   );

   modport master (
      output fetch_req, ir_ack, pc_load, pc_target, pc_skip, mem_rdata, mem_ack,
      input  ir_valid, opcode, operand, pc, mem_rd, mem_addr, busy
   );
endinterface

// File: rtl/riscy_fetch.sv
// RISCY fetch stage: PC/IR with a mem_rd/mem_ack read, 2-cycle min latency, HOLD until ir_ack.
// Define RISCY_FETCH_COUNT_EN to add fetch_cnt, a saturating count of accepted instructions.
module riscy_fetch #(
   parameter int            AW       = 5,
   parameter int            DW       = 8,
   parameter int            OPW      = 3,
   parameter logic [AW-1:0] RESET_PC = '0
) (
   input  logic         CLK,
   input  logic         RST,
   riscy_fetch_if.slave bus
`ifdef RISCY_FETCH_COUNT_EN
   ,
   output logic [7:0]   fetch_cnt
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam logic [AW-1:0] PC_ONE = {{(AW-1){1'b0}}, 1'b1};

   state_t        state_q, state_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [DW-1:0] ir_q, ir_d;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;

      // Jumps/skips land before the state decision so a same-cycle fetch reads the new PC.
      if (state_q != RD) begin
         if (bus.pc_load)
            pc_d = bus.pc_target;
         else if (bus.pc_skip)
            pc_d = pc_q + PC_ONE;
      end

      case (state_q)
         IDLE: begin
            if (bus.fetch_req)
               state_d = RD;
         end
         RD: begin
            if (bus.mem_ack) begin
               ir_d    = bus.mem_rdata;
               pc_d    = pc_q + PC_ONE;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (bus.ir_ack)
               state_d = bus.fetch_req ? RD : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.mem_rd   = (state_q == RD);
   assign bus.busy     = (state_q == RD);
   assign bus.ir_valid = (state_q == HOLD);
   assign bus.mem_addr = pc_q;
   assign bus.pc       = pc_q;
   assign bus.opcode   = ir_q[DW-1:DW-OPW];
   assign bus.operand  = ir_q[AW-1:0];

`ifdef RISCY_FETCH_COUNT_EN
   logic [7:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (state_q == HOLD && bus.ir_ack && cnt_q != 8'hFF)
         cnt_d = cnt_q + 8'd1;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)
         cnt_q <= 8'd0;
      else
         cnt_q <= cnt_d;
   end

   assign fetch_cnt = cnt_q;
`endif

endmodule

// File: doc/riscy_fetch.md
# riscy_fetch

Instruction fetch stage for the RISCY processor. It holds the program counter and instruction register, reads one instruction word from program memory over a request/acknowledge handshake, and presents the decoded opcode/operand to the RISCY sequencer controller. The sequencer consumes its output and controls PC jumps and skips.

## Interface
- AW, 5: address width; operand width; PC width
- DW, 8: instruction/memory data width
- OPW, 3: opcode width; AW+OPW must equal DW
- RESET_PC, 0: PC value after reset

Ports:
- CLK  in  1  clock; all state updates on its rising edge
- RST  in  1  asynchronous, active-low reset
- fetch_req  in  1  sequencer requests a fetch at the current PC
- ir_valid  out  1  IR holds a fetched instruction not yet acknowledged
- ir_ack  in  1  sequencer accepts the instruction
- opcode  out  OPW  IR[DW-1:DW-OPW]
- operand  out  AW  IR[AW-1:0]
- pc  out  AW  current program counter
- pc_load  in  1  jump: PC <= pc_target
- pc_target  in  AW  jump target
- pc_skip  in  1  skip: PC <= PC+1
- mem_rd  out  1  memory read strobe
- mem_addr  out  AW  memory address (equals pc while mem_rd=1)
- mem_rdata  in  DW  memory read data, valid when mem_ack=1
- mem_ack  in  1  memory data valid
- busy  out  1  high in RD state

## Operation
- FSM states: IDLE, RD, HOLD. Reset: state IDLE, pc=RESET_PC, IR=0, ir_valid=0, mem_rd=0, busy=0, opcode=0, operand=0.
- IDLE: fetch_req=1 -> RD. Otherwise stay.
- RD: mem_rd=1, busy=1, mem_addr=pc. On mem_ack=1: IR<=mem_rdata, pc<=pc+1 (mod 2^AW), -> HOLD. No timeout; waits indefinitely.
- HOLD: ir_valid=1, IR stable. ir_ack=1 and fetch_req=1 -> RD; ir_ack=1 only -> IDLE; else stay.
- pc_load/pc_skip honoured only in IDLE and HOLD; ignored in RD. pc_load has priority over pc_skip when both are set. PC increment and skip wrap from 2^AW-1 to 0.
- PC update in HOLD does not alter IR or ir_valid.
- Same-cycle pc_load/pc_skip with a fetch_req that causes a transition to RD: the PC updates first, so the fetch reads from the updated PC (target or PC+1).
- mem_ack outside RD is ignored. ir_ack outside HOLD is ignored.
- RST asserted mid-fetch: immediate return to reset values; mem_rd drops asynchronously; any pending memory reply is discarded.

## Timing
- fetch_req sampled at edge N -> mem_rd=1 from edge N.
- mem_ack sampled at edge M (M>=N+1) -> ir_valid=1 and new pc from edge M; mem_rd=0 from edge M.
- Minimum fetch_req-to-ir_valid latency: 2 cycles (mem_ack high in the first RD cycle).
- ir_ack sampled at edge K -> ir_valid=0 from edge K, or mem_rd=1 from edge K for back-to-back fetch. Sustained throughput: one instruction per 2 cycles with a zero-wait memory.
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.

## Configuration
- RISCY_FETCH_COUNT_EN defined: adds output fetch_cnt[7:0]. The counter resets to 0, increments on each accepted instruction (HOLD and ir_ack=1), and saturates at 255. pc_load does not clear it.
- Macro undefined: the fetch_cnt port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset: RST=0 mid-RD with mem_rd=1 -> mem_rd=0, pc=0, ir_valid=0 immediately; stays idle after release.
- Zero-wait fetch: mem[0]=8'hA5, fetch_req pulse, mem_ack same cycle as mem_rd -> ir_valid after 2 cycles, opcode=3'b101, operand=5'h05, pc=1.
- Wait states: mem_ack delayed 3 cycles -> mem_rd held 4 cycles with mem_addr constant; ir_valid 1 cycle after mem_ack.
- Jump: in HOLD assert pc_load with pc_target=5'h1C plus pc_skip -> pc=1C (load wins); next fetch mem_addr=1C. pc_load in RD -> pc unchanged.
- Wrap: pc=5'h1F, fetch completes -> pc=0. pc_skip at pc=1F -> pc=0.
- Back-to-back: ir_ack and fetch_req held high for 16 fetches -> 16 instructions over 32 cycles. With RISCY_FETCH_COUNT_EN defined, fetch_cnt=16; after 300 accepts, fetch_cnt=255.
